pc_npc_register: RTL and testbench

Architectural PC/nPC register pair for the SPARC datapath. It sits directly downstream of the nPC multiplexer: it latches the selected next-nPC, shifts nPC into PC, and produces the +4/+8 sums the multiplexer selects from. It also runs the trap-entry sequence: save PC/nPC, then redirect to the trap base address.

---
 rtl/pc_npc_register.sv | 133 +++++++++++++
 tb/tb_pc_npc_register.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_npc_register.sv
// SPARC PC/nPC register pair with +4/+8 adders and a two-cycle trap-entry sequence.
// Optional build macro PC_MISALIGN_TRAP_EN: a misaligned nPC load raises Misalign and traps.
module pc_npc_register #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] RESET_NPC = 32'h0000_0004
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [31:0] nPC_In,
   input  logic        PC_Ld,
   input  logic        Trap_Req,
   input  logic [31:0] TBR_In,
   output logic [31:0] PC,
   output logic [31:0] nPC,
   output logic [31:0] Adder4_Out,
   output logic [31:0] Adder8_Out,
   output logic [31:0] Saved_PC,
   output logic [31:0] Saved_nPC,
   output logic        Save_Valid,
   output logic        Trap_Ack,
   output logic        Ready,
   output logic        Misalign
);

   // state      | meaning
   // ST_INIT    | one idle cycle after reset, PC/nPC held
   // ST_RUN     | normal operation, PC_Ld honoured
   // ST_TRAP_SAVE | capture PC/nPC into Saved_*
   // ST_TRAP_JUMP | redirect PC/nPC to TBR_In / TBR_In+4
   typedef enum logic [1:0] {
      ST_INIT      = 2'd0,
      ST_RUN       = 2'd1,
      ST_TRAP_SAVE = 2'd2,
      ST_TRAP_JUMP = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_npc;
   logic [31:0] r_saved_pc;
   logic [31:0] r_saved_npc;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_npc_nxt;
   logic [31:0] w_npc_load;
   logic        w_misalign_set;

`ifdef PC_MISALIGN_TRAP_EN
   logic r_misalign;

   assign w_npc_load     = nPC_In;
   assign w_misalign_set = (r_state == ST_RUN) && PC_Ld && (nPC_In[1:0] != 2'b00);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_misalign <= 1'b0;
      end else if (w_misalign_set) begin
         r_misalign <= 1'b1;
      end
   end

   assign Misalign = r_misalign;
`else
   // Without the misalign trap, loads are silently word-aligned.
   assign w_npc_load     = nPC_In & 32'hFFFF_FFFC;
   assign w_misalign_set = 1'b0;
   assign Misalign       = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= ST_INIT;
         r_pc    <= RESET_PC;
         r_npc   <= RESET_NPC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_npc   <= w_npc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_npc_nxt   = r_npc;
      case (r_state)
         ST_INIT: begin
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // Trap beats advance; a rejected misaligned load also traps.
            if (Trap_Req || w_misalign_set) begin
               w_state_nxt = ST_TRAP_SAVE;
            end else if (PC_Ld) begin
               w_pc_nxt  = r_npc;
               w_npc_nxt = w_npc_load;
            end
         end
         ST_TRAP_SAVE: begin
            w_state_nxt = ST_TRAP_JUMP;
         end
         ST_TRAP_JUMP: begin
            w_pc_nxt    = TBR_In;
            w_npc_nxt   = TBR_In + 32'd4;
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_saved_pc  <= 32'h0;
         r_saved_npc <= 32'h0;
      end else if (r_state == ST_TRAP_SAVE) begin
         r_saved_pc  <= r_pc;
         r_saved_npc <= r_npc;
      end
   end

   assign PC         = r_pc;
   assign nPC        = r_npc;
   assign Adder4_Out = r_npc + 32'd4;
   assign Adder8_Out = r_npc + 32'd8;
   assign Saved_PC   = r_saved_pc;
   assign Saved_nPC  = r_saved_npc;
   assign Save_Valid = (r_state == ST_TRAP_SAVE);
   assign Trap_Ack   = (r_state == ST_TRAP_JUMP);
   assign Ready      = (r_state == ST_RUN);

endmodule

// File: tb/tb_pc_npc_register.sv
// Self-checking bench for pc_npc_register: directed vector table, reset-mid-trap
// sequence, and randomized traffic against a behavioural model.
module tb_pc_npc_register;

   logic        clk;
   logic        rst_n;
   logic [31:0] npc_in;
   logic        pc_ld;
   logic        trap_req;
   logic [31:0] tbr_in;
   logic [31:0] pc, npc, add4, add8, spc, snpc;
   logic        save_valid, trap_ack, ready, misalign;

   int n_checks = 0;
   int n_errors = 0;

   pc_npc_register #(.RESET_PC(32'h0), .RESET_NPC(32'h4)) dut (
      .Clk(clk), .Reset_n(rst_n), .nPC_In(npc_in), .PC_Ld(pc_ld),
      .Trap_Req(trap_req), .TBR_In(tbr_in), .PC(pc), .nPC(npc),
      .Adder4_Out(add4), .Adder8_Out(add8), .Saved_PC(spc), .Saved_nPC(snpc),
      .Save_Valid(save_valid), .Trap_Ack(trap_ack), .Ready(ready), .Misalign(misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      logic        treq;
      logic [31:0] nin;
      logic [31:0] tbr;
      logic [31:0] pc;
      logic [31:0] npc;
      logic [31:0] spc;
      logic [31:0] snpc;
      logic        sv;
      logic        ack;
      logic        rdy;
   } vec_t;

   vec_t vecs[17];

   // Behavioural model: pipeline position of the in-flight trap counted in cycles.
   logic [31:0] m_pc, m_npc, m_spc, m_snpc;
   bit          m_first;
   int          m_trap_age;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_npc = 32'h4; m_spc = 32'h0; m_snpc = 32'h0;
      m_first = 1'b1; m_trap_age = -1;
   endtask

   task automatic model_edge(input logic ld, input logic treq,
                             input logic [31:0] nin, input logic [31:0] tbr);
      if (m_first) begin
         m_first = 1'b0;
      end else if (m_trap_age == 0) begin
         m_spc = m_pc; m_snpc = m_npc; m_trap_age = 1;
      end else if (m_trap_age == 1) begin
         m_pc = tbr; m_npc = tbr + 32'd4; m_trap_age = -1;
      end else if (treq) begin
         m_trap_age = 0;
      end else if (ld) begin
         m_pc = m_npc; m_npc = {nin[31:2], 2'b00};
      end
   endtask

   task automatic model_check(input int idx);
      chk($sformatf("rnd%0d pc", idx), pc, m_pc);
      chk($sformatf("rnd%0d npc", idx), npc, m_npc);
      chk($sformatf("rnd%0d add4", idx), add4, m_npc + 32'd4);
      chk($sformatf("rnd%0d add8", idx), add8, m_npc + 32'd8);
      chk($sformatf("rnd%0d spc", idx), spc, m_spc);
      chk($sformatf("rnd%0d snpc", idx), snpc, m_snpc);
      chk($sformatf("rnd%0d sv", idx), save_valid, m_trap_age == 0);
      chk($sformatf("rnd%0d ack", idx), trap_ack, m_trap_age == 1);
      chk($sformatf("rnd%0d rdy", idx), ready, !m_first && m_trap_age < 0);
      chk($sformatf("rnd%0d mis", idx), misalign, 1'b0);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 32'h8,        32'h0,        32'h0,        32'h4,        32'h0,        32'h0,  1'b0, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 1'b0, 32'h8,        32'h0,        32'h4,        32'h8,        32'h0,        32'h0,  1'b0, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, 32'hC,        32'h0,        32'h8,        32'hC,        32'h0,        32'h0,  1'b0, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 32'h40,       32'h0,        32'hC,        32'h40,       32'h0,        32'h0,  1'b0, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, 1'b0, 32'h10,       32'h0,        32'h40,       32'h10,       32'h0,        32'h0,  1'b0, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 32'h14,       32'h0,        32'h10,       32'h14,       32'h0,        32'h0,  1'b0, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 1'b1, 32'h99,       32'h800,      32'h10,       32'h14,       32'h0,        32'h0,  1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 32'h99,       32'h800,      32'h10,       32'h14,       32'h10,       32'h14, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h800,      32'h800,      32'h804,      32'h10,       32'h14, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,       32'h804,      32'hFFFF_FFFC, 32'h10,      32'h14, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 32'h22,       32'h0,        32'hFFFF_FFFC, 32'h20,      32'h10,       32'h14, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 32'h0,        32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h20,     32'h10,       32'h14, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 32'h0,        32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h20,     32'hFFFF_FFFC, 32'h20, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 32'h44,       32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,      32'hFFFF_FFFC, 32'h20, 1'b0, 1'b0, 1'b1};
      vecs[14] = '{1'b1, 1'b1, 32'h48,       32'h0,        32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 32'h20, 1'b1, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 32'h0,  1'b0, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 32'h0,        32'h100,      32'h100,      32'h104,      32'hFFFF_FFFC, 32'h0,  1'b0, 1'b0, 1'b1};

      rst_n = 1'b0; pc_ld = 1'b0; trap_req = 1'b0; npc_in = 32'h0; tbr_in = 32'h0;
      #12 rst_n = 1'b1;
      #1;
      chk("reset pc", pc, 32'h0);
      chk("reset npc", npc, 32'h4);
      chk("reset add4", add4, 32'h8);
      chk("reset add8", add8, 32'hC);
      chk("reset ready", ready, 1'b0);
      chk("reset sv", save_valid, 1'b0);
      chk("reset ack", trap_ack, 1'b0);
      chk("reset spc", spc, 32'h0);
      chk("reset mis", misalign, 1'b0);

      for (int i = 0; i < 17; i++) begin
         pc_ld = vecs[i].ld; trap_req = vecs[i].treq;
         npc_in = vecs[i].nin; tbr_in = vecs[i].tbr;
         @(posedge clk); #1;
         chk($sformatf("vec%0d pc", i), pc, vecs[i].pc);
         chk($sformatf("vec%0d npc", i), npc, vecs[i].npc);
         chk($sformatf("vec%0d add4", i), add4, vecs[i].npc + 32'd4);
         chk($sformatf("vec%0d add8", i), add8, vecs[i].npc + 32'd8);
         chk($sformatf("vec%0d spc", i), spc, vecs[i].spc);
         chk($sformatf("vec%0d snpc", i), snpc, vecs[i].snpc);
         chk($sformatf("vec%0d sv", i), save_valid, vecs[i].sv);
         chk($sformatf("vec%0d ack", i), trap_ack, vecs[i].ack);
         chk($sformatf("vec%0d rdy", i), ready, vecs[i].rdy);
         chk($sformatf("vec%0d mis", i), misalign, 1'b0);
      end

      // Reset while in TRAP_SAVE abandons the trap completely.
      pc_ld = 1'b0; trap_req = 1'b1; tbr_in = 32'h300;
      @(posedge clk); #1;
      chk("rst_mid sv", save_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid pc", pc, 32'h0);
      chk("rst_mid npc", npc, 32'h4);
      chk("rst_mid spc", spc, 32'h0);
      chk("rst_mid snpc", snpc, 32'h0);
      chk("rst_mid sv0", save_valid, 1'b0);
      chk("rst_mid ready", ready, 1'b0);
      trap_req = 1'b0;
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("post_rst%0d ack", i), trap_ack, 1'b0);
         chk($sformatf("post_rst%0d pc", i), pc, 32'h0);
         chk($sformatf("post_rst%0d rdy", i), ready, 1'b1);
      end

      // Randomized traffic against the model, starting from a fresh reset.
      #2 rst_n = 1'b0;
      model_reset();
      #1 rst_n = 1'b1;
      model_check(-1);
      for (int i = 0; i < 3000; i++) begin
         pc_ld    = 1'($urandom_range(0, 1));
         trap_req = ($urandom_range(0, 7) == 0);
         npc_in   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
         tbr_in   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
         @(posedge clk);
         model_edge(pc_ld, trap_req, npc_in, tbr_in);
         #1;
         model_check(i);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst_n = 1'b0;
            model_reset();
            #1;
            model_check(i);
            rst_n = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
